// File: rtl/clk_gate_pkg.sv
// Shared types and limits for the idle-driven clock-gating controller.
package clk_gate_pkg;

  localparam int CG_MAX_CH = 32;

  typedef enum logic [1:0] {
    CG_RUN   = 2'd0,
    CG_GATED = 2'd1,
    CG_WAKE  = 2'd2
  } cg_state_e;

endpackage

// File: rtl/clk_gate_ch.sv
// One gating channel: RUN/GATED/WAKE FSM with idle and wake counters.
// All outputs come straight from flops.
module clk_gate_ch
  import clk_gate_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int WAKE_CYC = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [CNT_W-1:0] i_idle_thresh,
  input  logic             i_busy,
  input  logic             i_force_on,
  output logic             o_clk_en,
  output logic             o_rdy,
  output logic             o_gated
);

  localparam int WCNT_W = (WAKE_CYC > 1) ? $clog2(WAKE_CYC) : 1;
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WAKE_CYC - 1);

  cg_state_e         r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [WCNT_W-1:0] r_wcnt, w_wcnt_nxt;
  logic              r_clk_en, w_clk_en_nxt;
  logic              r_rdy, w_rdy_nxt;
  logic              r_gated, w_gated_nxt;

  logic              w_active;
  logic [CNT_W:0]    w_cnt_inc;
  logic              w_thresh_hit;
  logic [CNT_W-1:0]  w_cnt_sat;

  assign w_active     = i_busy | i_force_on;
  // One extra bit so cnt+1 at the saturation value still compares correctly.
  assign w_cnt_inc    = {1'b0, r_cnt} + (CNT_W + 1)'(1);
  assign w_thresh_hit = (i_idle_thresh != '0) && (w_cnt_inc >= {1'b0, i_idle_thresh});
  assign w_cnt_sat    = (&r_cnt) ? r_cnt : w_cnt_inc[CNT_W-1:0];

  // NOTE: every always_comb output gets a default first, so no latch is inferred.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_wcnt_nxt   = r_wcnt;
    w_clk_en_nxt = r_clk_en;
    w_rdy_nxt    = r_rdy;
    w_gated_nxt  = r_gated;
    unique case (r_state)
      CG_RUN: begin
        if (w_active) begin
          w_cnt_nxt = '0;
        end else if (w_thresh_hit) begin
          w_state_nxt  = CG_GATED;
          w_clk_en_nxt = 1'b0;
          w_rdy_nxt    = 1'b0;
          w_gated_nxt  = 1'b1;
          w_cnt_nxt    = '0;
        end else begin
          w_cnt_nxt = w_cnt_sat;
        end
      end
      CG_GATED: begin
        if (w_active) begin
          w_state_nxt  = CG_WAKE;
          w_clk_en_nxt = 1'b1;
          w_gated_nxt  = 1'b0;
          w_wcnt_nxt   = '0;
        end
      end
      CG_WAKE: begin
        w_wcnt_nxt = r_wcnt + WCNT_W'(1);
        if (r_wcnt == WCNT_LAST) begin
          w_state_nxt = CG_RUN;
          w_rdy_nxt   = 1'b1;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt  = CG_RUN;
        w_clk_en_nxt = 1'b1;
        w_rdy_nxt    = 1'b1;
        w_gated_nxt  = 1'b0;
        w_cnt_nxt    = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= CG_RUN;
      r_cnt    <= '0;
      r_wcnt   <= '0;
      r_clk_en <= 1'b1;
      r_rdy    <= 1'b1;
      r_gated  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_wcnt   <= w_wcnt_nxt;
      r_clk_en <= w_clk_en_nxt;
      r_rdy    <= w_rdy_nxt;
      r_gated  <= w_gated_nxt;
    end
  end

  assign o_clk_en = r_clk_en;
  assign o_rdy    = r_rdy;
  assign o_gated  = r_gated;

endmodule

// File: rtl/ctech_lib_clk_gate_and.sv
// Behavioural model of the AND-type integrated clock-gate cell.
// The enable is latched while clk is low so gclk never glitches.
module ctech_lib_clk_gate_and (
  input  logic clk,
  input  logic en,
  output logic gclk
);

  logic r_en_lat;

  // NOTE: this latch is intentional; it is the glitch filter of the gate cell.
  always_latch begin
    if (!clk) r_en_lat <= en;
  end

  assign gclk = clk & r_en_lat;

endmodule

// File: rtl/clk_gate_idle_ctrl.sv
// Multi-channel idle clock-gating controller: one FSM and one gate cell per channel.
// Scan test enable forces every gate open without disturbing channel state.
module clk_gate_idle_ctrl
  import clk_gate_pkg::*;
#(
  parameter int N_CH     = 4,
  parameter int CNT_W    = 8,
  parameter int WAKE_CYC = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             te,
  input  logic [CNT_W-1:0] idle_thresh,
  input  logic [N_CH-1:0]  busy,
  input  logic [N_CH-1:0]  force_on,
  output logic [N_CH-1:0]  clkout,
  output logic [N_CH-1:0]  clk_en,
  output logic [N_CH-1:0]  rdy,
  output logic [N_CH-1:0]  gated
);

  if (N_CH < 1 || N_CH > CG_MAX_CH) begin : g_bad_n_ch
    $error("clk_gate_idle_ctrl: N_CH must be in 1..%0d", CG_MAX_CH);
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("clk_gate_idle_ctrl: CNT_W must be >= 1");
  end
  if (WAKE_CYC < 1) begin : g_bad_wake_cyc
    $error("clk_gate_idle_ctrl: WAKE_CYC must be >= 1");
  end

  logic [N_CH-1:0] w_gate_en;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    clk_gate_ch #(
      .CNT_W    (CNT_W),
      .WAKE_CYC (WAKE_CYC)
    ) u_ch (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_idle_thresh (idle_thresh),
      .i_busy        (busy[i]),
      .i_force_on    (force_on[i]),
      .o_clk_en      (clk_en[i]),
      .o_rdy         (rdy[i]),
      .o_gated       (gated[i])
    );

    assign w_gate_en[i] = clk_en[i] | te;

    ctech_lib_clk_gate_and u_icg (
      .clk  (clk),
      .en   (w_gate_en[i]),
      .gclk (clkout[i])
    );
  end

endmodule

// File: tb/tb_clk_gate_idle_ctrl.sv
// Directed bench for clk_gate_idle_ctrl (N_CH=4, CNT_W=8, WAKE_CYC=2).
// Inputs change 1 ns after a rising edge; outputs are sampled at the same point.
module tb_clk_gate_idle_ctrl;

  logic       clk;
  logic       rst;
  logic       te;
  logic [7:0] idle_thresh;
  logic [3:0] busy;
  logic [3:0] force_on;
  logic [3:0] clkout;
  logic [3:0] clk_en;
  logic [3:0] rdy;
  logic [3:0] gated;

  int n_checks = 0;
  int n_fail   = 0;

  clk_gate_idle_ctrl #(
    .N_CH     (4),
    .CNT_W    (8),
    .WAKE_CYC (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .te          (te),
    .idle_thresh (idle_thresh),
    .busy        (busy),
    .force_on    (force_on),
    .clkout      (clkout),
    .clk_en      (clk_en),
    .rdy         (rdy),
    .gated       (gated)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic [3:0] e_en,
                            input logic [3:0] e_rdy, input logic [3:0] e_gated);
    check({tag, ".clk_en"}, 32'(clk_en), 32'(e_en));
    check({tag, ".rdy"},    32'(rdy),    32'(e_rdy));
    check({tag, ".gated"},  32'(gated),  32'(e_gated));
  endtask

  logic [3:0] seen_gated;
  logic [3:0] seen_en_low;

  initial begin
    rst = 1'b1; te = 1'b0; idle_thresh = 8'd0; busy = 4'h0; force_on = 4'h0;

    // Reset
    tick(); tick();
    check_outs("reset", 4'hF, 4'hF, 4'h0);
    check("reset.clkout_hi", 32'(clkout), 32'hF);
    @(negedge clk); #1;
    check("reset.clkout_lo", 32'(clkout), 32'h0);
    tick();
    rst = 1'b0;

    // Threshold 0: never gates
    seen_gated = 4'h0; seen_en_low = 4'h0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      seen_gated  |= gated;
      seen_en_low |= ~clk_en;
    end
    check("thr0.gated_seen", 32'(seen_gated), 32'h0);
    check("thr0.en_low_seen", 32'(seen_en_low), 32'h0);

    // Idle gating of ch0 with threshold 5
    busy = 4'hF; idle_thresh = 8'd5;
    tick();
    busy = 4'hE;
    repeat (4) tick();
    check("gate0.before", 32'(clk_en), 32'hF);
    tick();
    check_outs("gate0.after", 4'hE, 4'hE, 4'h1);
    check("gate0.clkout_last", 32'(clkout), 32'hF);
    tick();
    check("gate0.clkout_flat", 32'(clkout), 32'hE);

    // Gate ch1 as well
    busy = 4'hC;
    repeat (5) tick();
    check_outs("gate1", 4'hC, 4'hC, 4'h3);

    // One-cycle busy pulse wakes ch1
    busy = 4'hE;
    tick();
    check_outs("wake1.j", 4'hE, 4'hC, 4'h1);
    busy = 4'hC;
    tick();
    check("wake1.j1.rdy", 32'(rdy), 32'hC);
    tick();
    check_outs("wake1.j2", 4'hE, 4'hE, 4'h1);

    // Gate ch1 and ch2
    busy = 4'h8;
    repeat (5) tick();
    check_outs("gate12", 4'h8, 4'h8, 4'h7);

    // force_on wakes ch2
    force_on = 4'h4;
    tick();
    check_outs("force2.j", 4'hC, 4'h8, 4'h3);
    tick(); tick();
    check("force2.rdy", 32'(rdy), 32'hC);

    // Scan test enable opens every gate but leaves state alone
    te = 1'b1;
    tick();
    check("te.clkout", 32'(clkout), 32'hF);
    check_outs("te.state", 4'hC, 4'hC, 4'h3);
    te = 1'b0;
    tick();
    check("te_off.clkout", 32'(clkout), 32'hC);

    // Busy on the threshold cycle keeps ch3 running and clears its count
    busy = 4'h0;
    seen_en_low = 4'h0;
    repeat (4) begin
      tick();
      seen_en_low |= ~clk_en;
    end
    busy = 4'h8;
    tick();
    seen_en_low |= ~clk_en;
    busy = 4'h0;
    repeat (4) begin
      tick();
      seen_en_low |= ~clk_en;
    end
    check("bthr.ch3_never_low", 32'(seen_en_low[3]), 32'h0);
    check_outs("bthr.hold", 4'hC, 4'hC, 4'h3);
    tick();
    check_outs("bthr.gate3", 4'h4, 4'h4, 4'hB);

    // Reset abandons a wake in progress
    busy = 4'h1;
    tick();
    check_outs("rwake.wake", 4'h5, 4'h4, 4'hA);
    rst = 1'b1;
    tick();
    check_outs("rwake.reset", 4'hF, 4'hF, 4'h0);
    rst = 1'b0; force_on = 4'h0;

    // Lowering the threshold below the running count gates on the next idle sample
    idle_thresh = 8'd200; busy = 4'hF;
    tick();
    busy = 4'h0;
    repeat (50) tick();
    check_outs("lower.before", 4'hF, 4'hF, 4'h0);
    idle_thresh = 8'd3;
    tick();
    check_outs("lower.after", 4'h0, 4'h0, 4'hF);

    // Minimum gating latency with threshold 1
    idle_thresh = 8'd1; busy = 4'hF;
    tick();
    check_outs("t1.wake", 4'hF, 4'h0, 4'h0);
    busy = 4'h0;
    tick(); tick();
    check_outs("t1.run", 4'hF, 4'hF, 4'h0);
    tick();
    check_outs("t1.gate", 4'h0, 4'h0, 4'hF);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
